uart_tx_engine: RTL

Transmit datapath of the UART: buffers bytes written over the processor register interface in a FIFO, serializes them into start/data/parity/stop frames at a programmable bit rate, and drives UART_SOUT. Sits directly downstream of the APB register decode and drives the serial pin. Also generates the DMA transmit request TXDRDYn.

---
 rtl/uart_tx_engine.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit FIFO and frame serializer
// Optional parity insertion is built only when UART_TX_PARITY_EN is defined.
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic [DIV_W-1:0]            divisor,
  input  logic [1:0]                  data_bits,
  input  logic                        stop2,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        tx_enable,
  output logic                        UART_SOUT,
  output logic                        TXDRDYn,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic                        tx_empty,
  output logic                        tx_full,
  output logic                        tx_busy,
  output logic                        tx_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  logic [2:0]       state;
  logic [DIV_W-1:0] cnt, div_q;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic [1:0]       db_q;
  logic             stop2_q, stop_idx;
  logic             bit_end, last_data, last_stop, start_ok, frame_done;

`ifdef UART_TX_PARITY_EN
  logic             par_en_q, par_bit_q;
  logic [7:0]       head_mask;
  assign head_mask = 8'hFF >> (2'd3 - data_bits);
`else
  logic             unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

  assign tx_empty = (tx_level == '0);
  assign tx_full  = (tx_level == LW'(FIFO_DEPTH));
  assign TXDRDYn  = (tx_level > LW'(FIFO_DEPTH / 2));

  // A write into a full FIFO still lands when the same cycle frees a slot.
  assign push = wr_en && (!tx_full || pop);

  assign bit_end    = (cnt == '0);
  assign last_data  = (bit_idx == ({1'b0, db_q} + 3'd4));
  assign last_stop  = !stop2_q || stop_idx;
  assign start_ok   = tx_enable && !tx_empty;
  assign frame_done = (state == S_STOP) && bit_end && last_stop;
  assign pop        = start_ok && ((state == S_IDLE) || frame_done);

  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_level <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      tx_ovf <= wr_en && !push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tx_level <= tx_level + 1'b1;
        2'b01:   tx_level <= tx_level - 1'b1;
        default: tx_level <= tx_level;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_q    <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      db_q     <= '0;
      stop2_q  <= 1'b0;
      stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else if (pop) begin
      // Frame configuration is captured here and held until the next pop.
      state    <= S_START;
      shift    <= mem[rd_ptr];
      cnt      <= divisor;
      div_q    <= divisor;
      db_q     <= data_bits;
      stop2_q  <= stop2;
      stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= parity_en;
      par_bit_q <= (^(mem[rd_ptr] & head_mask)) ^ parity_odd;
`endif
    end else begin
      case (state)
        S_IDLE: cnt <= cnt;
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            cnt     <= div_q;
            bit_idx <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt     <= div_q;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (last_data) begin
              stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
              state    <= par_en_q ? S_PARITY : S_STOP;
`else
              state    <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            cnt      <= div_q;
            stop_idx <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cnt <= div_q;
            if (last_stop) state    <= S_IDLE;
            else           stop_idx <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The pin lags the state register by one cycle so it is always a clean flop.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      UART_SOUT <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      tx_busy <= (state != S_IDLE);
      case (state)
        S_START:  UART_SOUT <= 1'b0;
        S_DATA:   UART_SOUT <= shift[0];
`ifdef UART_TX_PARITY_EN
        S_PARITY: UART_SOUT <= par_bit_q;
`endif
        default:  UART_SOUT <= 1'b1;
      endcase
    end
  end

endmodule
